// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: single-outstanding instruction fetch stage feeding the decoder
//   clk, rst_n                        clock, asynchronous active-low reset
//   imem_req_valid/ready/addr         request channel to instruction memory (addr = pc)
//   imem_resp_valid/ready/data/err    response channel from instruction memory
//   pc, inst, inst_valid, inst_ready  held instruction presented to decode, retired on inst_ready
//   next_pc                           PC to fetch after retire, sampled on retire only
//   fetch_err, err_cause              sticky error flag and cause (01 bus error, 10 misaligned)
module inst_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    output logic              imem_resp_ready,
    input  logic [31:0]       imem_resp_data,
    input  logic              imem_resp_err,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       inst,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic [ADDR_W-1:0] next_pc,
    output logic              fetch_err,
    output logic [1:0]        err_cause
);
    typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, HALT} state_t;
    state_t state;
    assign imem_req_addr = pc;
    // Handshake outputs are registered alongside the state so each one
    // changes exactly on the transition into or out of its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= BOOT;
            pc              <= RESET_PC;
            inst            <= 32'h0;
            inst_valid      <= 1'b0;
            imem_req_valid  <= 1'b0;
            imem_resp_ready <= 1'b0;
            fetch_err       <= 1'b0;
            err_cause       <= 2'b00;
        end else begin
            case (state)
                BOOT: begin
                    state          <= REQ;
                    imem_req_valid <= 1'b1;
                end
                REQ: if (imem_req_ready) begin
                    state           <= WAIT;
                    imem_req_valid  <= 1'b0;
                    imem_resp_ready <= 1'b1;
                end
                WAIT: if (imem_resp_valid) begin
                    imem_resp_ready <= 1'b0;
                    if (imem_resp_err) begin
                        state     <= HALT;
                        fetch_err <= 1'b1;
                        err_cause <= 2'b01;
                    end else begin
                        state      <= HOLD;
                        inst       <= imem_resp_data;
                        inst_valid <= 1'b1;
                    end
                end
                HOLD: if (inst_ready) begin
                    inst_valid <= 1'b0;
                    if (next_pc[1:0] == 2'b00) begin
                        state          <= REQ;
                        pc             <= next_pc;
                        imem_req_valid <= 1'b1;
                    end else begin
                        state     <= HALT;
                        fetch_err <= 1'b1;
                        err_cause <= 2'b10;
                    end
                end
                default: state <= HALT;
            endcase
        end
    end
endmodule
